// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin arbiter sharing one UART transmitter among
// NREQ byte sources, with per-byte pacing and atomic message locking.
module uart_tx_sched #(
    parameter int NREQ         = 4,
    parameter int BYTE_CYCLES  = 6800,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int CW           = 16
) (
    input  logic                    sys_clk_i,
    input  logic                    sys_rst_i,
    input  logic [NREQ-1:0]         req_valid_i,
    input  logic [8*NREQ-1:0]       req_data_i,
    input  logic [NREQ-1:0]         req_last_i,
    output logic [NREQ-1:0]         req_ready_o,
    output logic                    uart_wr_o,
    output logic [7:0]              uart_dat_o,
    output logic [$clog2(NREQ)-1:0] grant_o,
    output logic                    locked_o,
    output logic                    busy_o
);
    localparam int GW = $clog2(NREQ);
    localparam logic [GW:0] N_W = (GW+1)'(NREQ);
    localparam logic [CW-1:0] PACE_INIT = CW'(BYTE_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST = CW'(LOCK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t state_q, state_d;
    logic [GW-1:0] ptr_q;
    logic [GW-1:0] win;
    logic win_ok;
    logic accept;
    logic [CW-1:0] pace_q;
    logic [CW-1:0] tout_q;

    function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] base,
                                             input int off);
        logic [GW:0] s;
        s = {1'b0, base} + (GW+1)'(off);
        if (s >= N_W) s = s - N_W;
        return s[GW-1:0];
    endfunction

    // Reverse scan so the last hit is the first valid at or after ptr_q.
    always_comb begin
        win = grant_o;
        win_ok = 1'b0;
        if (locked_o) begin
            win_ok = req_valid_i[grant_o];
        end else begin
            for (int i = NREQ - 1; i >= 0; i--) begin
                if (req_valid_i[rr_idx(ptr_q, i)]) begin
                    win = rr_idx(ptr_q, i);
                    win_ok = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        req_ready_o = '0;
        accept = (state_q == S_IDLE) && win_ok && !sys_rst_i;
        if (accept) req_ready_o[win] = 1'b1;
        unique case (state_q)
            S_IDLE:  if (accept) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (pace_q == '0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            uart_dat_o <= '0;
            grant_o    <= '0;
            locked_o   <= 1'b0;
            ptr_q      <= '0;
            pace_q     <= '0;
            tout_q     <= '0;
        end else begin
            if (accept) begin
                uart_dat_o <= req_data_i[{win, 3'b000} +: 8];
                grant_o    <= win;
                locked_o   <= ~req_last_i[win];
                tout_q     <= '0;
                if (req_last_i[win]) ptr_q <= rr_idx(win, 1);
            end else if (!locked_o) begin
                tout_q <= '0;
            end else if (state_q == S_IDLE && !req_valid_i[grant_o]) begin
                // Owner went quiet mid-message: release after the timeout.
                if (tout_q == TO_LAST) begin
                    locked_o <= 1'b0;
                    ptr_q    <= rr_idx(grant_o, 1);
                    tout_q   <= '0;
                end else begin
                    tout_q <= tout_q + 1'b1;
                end
            end
            if (state_q == S_ISSUE) begin
                pace_q <= PACE_INIT;
            end else if (state_q == S_WAIT && pace_q != '0) begin
                pace_q <= pace_q - 1'b1;
            end
        end
    end

    assign uart_wr_o = (state_q == S_ISSUE);
    assign busy_o    = (state_q != S_IDLE);

endmodule
